// File: rtl/star_scheduler.sv
// star_scheduler: game FSM, LFSR lane spawner and per-lane hit/miss judge for four star lanes.
// Build option: define STAR_SCHED_PENALTY_EN to turn off-window presses on a falling star into misses.
module star_scheduler #(
  parameter int unsigned SPAWN_PERIOD = 50,
  parameter int unsigned HIT_V_MIN    = 400,
  parameter int unsigned HIT_V_MAX    = 460,
  parameter int unsigned BOTTOM_V     = 480,
  parameter int unsigned FX_TICKS     = 20,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] btn,
  input  logic [9:0] star_v_0,
  input  logic [9:0] star_v_1,
  input  logic [9:0] star_v_2,
  input  logic [9:0] star_v_3,
  output logic [2:0] star_state_0,
  output logic [2:0] star_state_1,
  output logic [2:0] star_state_2,
  output logic [2:0] star_state_3,
  output logic [7:0] score,
  output logic [7:0] miss_cnt,
  output logic       running
);

  localparam int unsigned    SPW        = $clog2(SPAWN_PERIOD);
  localparam int unsigned    FXW        = (FX_TICKS > 1) ? $clog2(FX_TICKS) : 1;
  localparam logic [SPW-1:0] SPAWN_LAST = SPW'(SPAWN_PERIOD - 1);
  localparam logic [FXW-1:0] FX_LAST    = FXW'(FX_TICKS - 1);
  localparam logic [9:0]     V_MIN      = 10'(HIT_V_MIN);
  localparam logic [9:0]     V_MAX      = 10'(HIT_V_MAX);
  localparam logic [9:0]     V_BOTTOM   = 10'(BOTTOM_V);

  typedef enum logic [1:0] {G_STOP = 2'd0, G_RUN = 2'd1, G_PAUSE = 2'd2} game_e;
  typedef enum logic [2:0] {L_IDLE = 3'd0, L_FALL = 3'd1, L_HIT = 3'd2, L_MISS = 3'd3} lane_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] n);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'd0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  game_e          game_q, game_d;
  logic           running_q, running_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [SPW-1:0] spawn_q, spawn_d;
  logic [7:0]     score_q, score_d;
  logic [7:0]     miss_q, miss_d;
  lane_e          lane_q [4];
  lane_e          lane_d [4];
  logic [FXW-1:0] fx_q [4];
  logic [FXW-1:0] fx_d [4];

  logic [9:0] v_s [4];
  logic [3:0] in_win_s;
  logic [3:0] penalty_s;
  logic [3:0] idle_s;
  logic [1:0] cand_s;
  logic [1:0] spawn_lane_s;
  logic       spawn_ok_s;
  logic       spawn_now_s;
  logic [2:0] hit_n_s;
  logic [2:0] miss_n_s;

  assign v_s[0] = star_v_0;
  assign v_s[1] = star_v_1;
  assign v_s[2] = star_v_2;
  assign v_s[3] = star_v_3;

  // Per-lane hit window and off-window press penalty
  always_comb begin
    in_win_s  = 4'd0;
    penalty_s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      in_win_s[i] = (v_s[i] >= V_MIN) && (v_s[i] <= V_MAX);
`ifdef STAR_SCHED_PENALTY_EN
      penalty_s[i] = btn[i] && !in_win_s[i];
`else
      penalty_s[i] = 1'b0;
`endif
    end
  end

  // Spawn lane: first IDLE lane probing upward from the LFSR candidate (later probes overridden by earlier)
  always_comb begin
    idle_s       = 4'd0;
    cand_s       = 2'd0;
    spawn_lane_s = 2'd0;
    spawn_ok_s   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_s[i] = (lane_q[i] == L_IDLE);
    end
    for (int k = 3; k >= 0; k--) begin
      cand_s       = lfsr_q[1:0] + 2'(k);
      spawn_lane_s = idle_s[cand_s] ? cand_s : spawn_lane_s;
      spawn_ok_s   = spawn_ok_s | idle_s[cand_s];
    end
    spawn_now_s = (spawn_q == SPAWN_LAST) && spawn_ok_s;
  end

  // Game FSM, lane FSMs, spawn counter, LFSR and scoring next state
  always_comb begin
    game_d   = game_q;
    lfsr_d   = lfsr_q;
    spawn_d  = spawn_q;
    score_d  = score_q;
    miss_d   = miss_q;
    hit_n_s  = 3'd0;
    miss_n_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = lane_q[i];
      fx_d[i]   = fx_q[i];
    end

    if (start) begin
      game_d  = pause ? G_PAUSE : G_RUN;
      spawn_d = '0;
      score_d = 8'd0;
      miss_d  = 8'd0;
      for (int i = 0; i < 4; i++) begin
        lane_d[i] = L_IDLE;
        fx_d[i]   = '0;
      end
    end else begin
      case (game_q)
        G_STOP:  game_d = G_STOP;
        G_PAUSE: game_d = pause ? G_PAUSE : G_RUN;
        G_RUN: begin
          game_d  = pause ? G_PAUSE : G_RUN;
          lfsr_d  = lfsr_next(lfsr_q);
          spawn_d = (spawn_q == SPAWN_LAST) ? '0 : spawn_q + SPW'(1);
          for (int i = 0; i < 4; i++) begin
            case (lane_q[i])
              L_IDLE: lane_d[i] = (spawn_now_s && (spawn_lane_s == 2'(i))) ? L_FALL : L_IDLE;
              L_FALL: begin
                // A press inside the window wins even if the star also reached the bottom
                if (btn[i] && in_win_s[i]) begin
                  lane_d[i] = L_HIT;
                  hit_n_s   = hit_n_s + 3'd1;
                end else if ((v_s[i] >= V_BOTTOM) || penalty_s[i]) begin
                  lane_d[i] = L_MISS;
                  miss_n_s  = miss_n_s + 3'd1;
                end else begin
                  lane_d[i] = L_FALL;
                end
              end
              L_HIT, L_MISS: begin
                if (fx_q[i] == FX_LAST) begin
                  lane_d[i] = L_IDLE;
                  fx_d[i]   = '0;
                end else begin
                  fx_d[i]   = fx_q[i] + FXW'(1);
                end
              end
              default: begin
                lane_d[i] = L_IDLE;
                fx_d[i]   = '0;
              end
            endcase
          end
          score_d = sat_add(score_q, hit_n_s);
          miss_d  = sat_add(miss_q, miss_n_s);
        end
        default: game_d = G_STOP;
      endcase
    end
    running_d = (game_d != G_STOP);
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_q    <= G_STOP;
      running_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      spawn_q   <= '0;
      score_q   <= 8'd0;
      miss_q    <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= L_IDLE;
        fx_q[i]   <= '0;
      end
    end else begin
      game_q    <= game_d;
      running_q <= running_d;
      lfsr_q    <= lfsr_d;
      spawn_q   <= spawn_d;
      score_q   <= score_d;
      miss_q    <= miss_d;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= lane_d[i];
        fx_q[i]   <= fx_d[i];
      end
    end
  end

  assign star_state_0 = lane_q[0];
  assign star_state_1 = lane_q[1];
  assign star_state_2 = lane_q[2];
  assign star_state_3 = lane_q[3];
  assign score        = score_q;
  assign miss_cnt     = miss_q;
  assign running      = running_q;

endmodule
